// File: rtl/debug_reg_scheduler_pkg.sv
// Shared types and default geometry for the register-file debug snapshot scheduler.
package debug_screen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EXT  = 2'd2
  } dbg_sched_state_t;

  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int          DEF_AW       = 5;
  localparam int          DEF_DW       = 32;
  localparam int          DEF_CNT_W    = 16;

endpackage

// File: rtl/debug_reg_scheduler_if.sv
// Bundles the CPU debug port, display read port, debugger handshake and status of the scheduler.
interface debug_reg_scheduler_if
  import debug_screen_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int CNT_W = DEF_CNT_W
);
  logic             frame_start;
  logic             hold;
  logic [AW-1:0]    rf_addr;
  logic [DW-1:0]    rf_data;
  logic [AW-1:0]    disp_addr;
  logic [DW-1:0]    disp_data;
  logic             ext_req;
  logic [AW-1:0]    ext_addr;
  logic             ext_gnt;
  logic [DW-1:0]    ext_data;
  logic             snap_busy;
  logic             snap_done;
  logic [CNT_W-1:0] snap_count;

  modport slave (
    input  frame_start, hold, rf_data, disp_addr, ext_req, ext_addr,
    output rf_addr, disp_data, ext_gnt, ext_data, snap_busy, snap_done, snap_count
  );

  modport master (
    output frame_start, hold, rf_data, disp_addr, ext_req, ext_addr,
    input  rf_addr, disp_data, ext_gnt, ext_data, snap_busy, snap_done, snap_count
  );
endinterface

// File: rtl/debug_reg_scheduler_shadow_regs.sv
// Shadow copy of the register file: one write port, one combinational read port returning 0 out of range.
module debug_shadow_regs
  import debug_screen_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int          AW       = DEF_AW,
  parameter int          DW       = DEF_DW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(NUM_REGS); i++) mem_q[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (waddr == AW'(i)) mem_q[i] <= wdata;
      end
    end
  end

  // Addresses with no matching entry fall through to the zero default.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (raddr == AW'(i)) rdata = mem_q[i];
    end
  end

endmodule

// File: rtl/debug_reg_scheduler.sv
// Arbitrates the CPU register-file debug read port between a per-frame snapshot scan and an external debugger.
module debug_reg_scheduler
  import debug_screen_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int          AW       = DEF_AW,
  parameter int          DW       = DEF_DW,
  parameter int          CNT_W    = DEF_CNT_W
) (
  input logic                  clk,
  input logic                  resetn,
  debug_reg_scheduler_if.slave bus
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  dbg_sched_state_t state_q;
  logic [AW-1:0]    idx_q;
  logic [AW-1:0]    rf_addr_q;
  logic             pend_q;
  logic             pend_d;
  logic             ext_gnt_q;
  logic [DW-1:0]    ext_data_q;
  logic             snap_busy_q;
  logic             snap_done_q;
  logic [CNT_W-1:0] snap_count_q;
  logic             shadow_we;

  // A new frame request survives the cycle that consumes the previous one.
  assign pend_d    = bus.frame_start & ~bus.hold;
  assign shadow_we = (state_q == SCAN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rf_addr_q    <= '0;
      pend_q       <= 1'b0;
      ext_gnt_q    <= 1'b0;
      ext_data_q   <= '0;
      snap_busy_q  <= 1'b0;
      snap_done_q  <= 1'b0;
      snap_count_q <= '0;
    end else begin
      ext_gnt_q   <= 1'b0;
      snap_done_q <= 1'b0;
      if (pend_d) pend_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (bus.ext_req) begin
            state_q   <= EXT;
            rf_addr_q <= bus.ext_addr;
            ext_gnt_q <= 1'b1;
          end else if (pend_q) begin
            state_q     <= SCAN;
            idx_q       <= '0;
            rf_addr_q   <= '0;
            snap_busy_q <= 1'b1;
            pend_q      <= pend_d;
          end
        end

        EXT: begin
          ext_data_q <= bus.rf_data;
          rf_addr_q  <= '0;
          // Going straight to a pending scan keeps a busy debugger from starving the snapshot.
          if (pend_q) begin
            state_q     <= SCAN;
            idx_q       <= '0;
            snap_busy_q <= 1'b1;
            pend_q      <= pend_d;
          end else begin
            state_q <= IDLE;
          end
        end

        SCAN: begin
          if (idx_q == LAST_IDX) begin
            state_q      <= IDLE;
            rf_addr_q    <= '0;
            snap_busy_q  <= 1'b0;
            snap_done_q  <= 1'b1;
            snap_count_q <= snap_count_q + CNT_W'(1);
          end else begin
            idx_q     <= idx_q + AW'(1);
            rf_addr_q <= idx_q + AW'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  debug_shadow_regs #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW),
    .DW       (DW)
  ) u_shadow (
    .clk    (clk),
    .resetn (resetn),
    .we     (shadow_we),
    .waddr  (idx_q),
    .wdata  (bus.rf_data),
    .raddr  (bus.disp_addr),
    .rdata  (bus.disp_data)
  );

  assign bus.rf_addr    = rf_addr_q;
  assign bus.ext_gnt    = ext_gnt_q;
  assign bus.ext_data   = ext_data_q;
  assign bus.snap_busy  = snap_busy_q;
  assign bus.snap_done  = snap_done_q;
  assign bus.snap_count = snap_count_q;

endmodule

// File: tb/tb_debug_reg_scheduler.sv
// Bench for debug_reg_scheduler: vector tables, debugger read scoreboard and multi-cycle corner sequences.
module tb_debug_reg_scheduler;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] base;

  debug_reg_scheduler_if #(.AW(AW), .DW(DW), .CNT_W(CW)) bus ();

  debug_reg_scheduler #(
    .NUM_REGS (NR),
    .AW       (AW),
    .DW       (DW),
    .CNT_W    (CW)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Register file model: each register holds base + its own address.
  assign bus.rf_data = base + 32'(bus.rf_addr);

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          disp_tbl[4];
  vec_t          ext_tbl[4];
  int            errors = 0;
  int            checks = 0;
  int            done_cnt = 0;
  int            busy_cyc = 0;
  int            exp_snaps = 0;
  logic          gnt_seen = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Debugger data is due the cycle after each grant; compare against the oldest queued expectation.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (gnt_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ext_unexpected_grant: got data %0h with no request queued", bus.ext_data);
      end else begin
        e = exp_q.pop_front();
        check("ext_data", 64'(bus.ext_data), 64'(e));
      end
    end
    gnt_seen = bus.ext_gnt;
    if (bus.snap_done) done_cnt++;
    if (bus.snap_busy) busy_cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!bus.snap_busy && n < 20) begin
      step();
      n++;
    end
    check(name, 64'(bus.snap_busy), 64'(1));
  endtask

  task automatic ext_read(input logic [AW-1:0] a, input logic [DW-1:0] e, output int lat);
    exp_q.push_back(e);
    bus.ext_addr = a;
    bus.ext_req  = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus.ext_gnt && lat < 100);
    bus.ext_req = 1'b0;
  endtask

  task automatic check_disp(input string name, input logic [AW-1:0] a, input logic [DW-1:0] e);
    bus.disp_addr = a;
    #1;
    check(name, 64'(bus.disp_data), 64'(e));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rf_addr"},    64'(bus.rf_addr),    64'(0));
    check({tag, "_ext_gnt"},    64'(bus.ext_gnt),    64'(0));
    check({tag, "_ext_data"},   64'(bus.ext_data),   64'(0));
    check({tag, "_snap_busy"},  64'(bus.snap_busy),  64'(0));
    check({tag, "_snap_done"},  64'(bus.snap_done),  64'(0));
    check({tag, "_snap_count"}, 64'(bus.snap_count), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int grants;
    int maxw;
    int w;
    logic [AW-1:0] a;

    bus.frame_start = 1'b0;
    bus.hold        = 1'b0;
    bus.disp_addr   = '0;
    bus.ext_req     = 1'b0;
    bus.ext_addr    = '0;
    base            = 32'hA000_0000;

    disp_tbl[0] = '{5'd0,  32'hA000_0000};
    disp_tbl[1] = '{5'd5,  32'hA000_0005};
    disp_tbl[2] = '{5'd17, 32'hA000_0011};
    disp_tbl[3] = '{5'd31, 32'hA000_001F};
    ext_tbl[0]  = '{5'd7,  32'hA000_0007};
    ext_tbl[1]  = '{5'd0,  32'hA000_0000};
    ext_tbl[2]  = '{5'd31, 32'hA000_001F};
    ext_tbl[3]  = '{5'd12, 32'hA000_000C};

    // Reset state
    repeat (3) step();
    check_all_zero("reset");
    check_disp("reset_disp5", 5'd5, 32'h0);
    resetn = 1'b1;
    step();

    // Single snapshot
    done_cnt = 0;
    busy_cyc = 0;
    pulse_frame();
    wait_done(1, 80);
    repeat (3) step();
    exp_snaps = 1;
    check("snap1_done_cnt", 64'(done_cnt), 64'(1));
    check("snap1_busy_cycles", 64'(busy_cyc), 64'(32));
    check("snap1_count", 64'(bus.snap_count), 64'(exp_snaps));
    check("snap1_idle_rf_addr", 64'(bus.rf_addr), 64'(0));
    for (int i = 0; i < 4; i++) check_disp("snap1_disp", disp_tbl[i].addr, disp_tbl[i].exp);

    // Debugger reads from IDLE: grant on the next edge
    for (int i = 0; i < 4; i++) begin
      ext_read(ext_tbl[i].addr, ext_tbl[i].exp, lat);
      check("ext_idle_latency", 64'(lat), 64'(1));
      repeat (2) step();
    end
    check("ext_queue_drained", 64'(exp_q.size()), 64'(0));

    // frame_start and ext_req together: grant first, scan right after
    done_cnt = 0;
    exp_q.push_back(32'hA000_0003);
    bus.ext_addr    = 5'd3;
    bus.ext_req     = 1'b1;
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    bus.ext_req     = 1'b0;
    check("tie_ext_first", 64'(bus.ext_gnt), 64'(1));
    check("tie_not_busy_yet", 64'(bus.snap_busy), 64'(0));
    step();
    check("tie_scan_next", 64'(bus.snap_busy), 64'(1));
    wait_done(1, 80);
    repeat (3) step();
    exp_snaps++;
    check("tie_done_cnt", 64'(done_cnt), 64'(1));
    check("tie_snap_count", 64'(bus.snap_count), 64'(exp_snaps));

    // Debugger always requesting while frames arrive every 40 cycles
    done_cnt = 0;
    grants   = 0;
    maxw     = 0;
    w        = 0;
    a        = 5'(($urandom_range(0, 31)));
    bus.ext_addr = a;
    bus.ext_req  = 1'b1;
    exp_q.push_back(base + 32'(a));
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.frame_start = ((cyc % 40) == 0) && (cyc <= 160);
      step();
      if (bus.ext_gnt) begin
        grants++;
        if (w > maxw) maxw = w;
        w = 0;
        if (cyc >= 240) break;
        a = 5'(($urandom_range(0, 31)));
        bus.ext_addr = a;
        exp_q.push_back(base + 32'(a));
      end else begin
        w++;
      end
    end
    bus.frame_start = 1'b0;
    bus.ext_req     = 1'b0;
    repeat (3) step();
    exp_snaps += 5;
    check("ilv_done_cnt", 64'(done_cnt), 64'(5));
    check("ilv_wait_le_33", 64'(maxw <= 33), 64'(1));
    check("ilv_grants_interleave", 64'(grants > 10), 64'(1));
    check("ilv_queue_drained", 64'(exp_q.size()), 64'(0));
    check("ilv_snap_count", 64'(bus.snap_count), 64'(exp_snaps));

    // hold blocks new snapshots and keeps the shadow
    bus.hold = 1'b1;
    base     = 32'hB000_0000;
    done_cnt = 0;
    busy_cyc = 0;
    pulse_frame();
    repeat (40) step();
    bus.hold = 1'b0;
    repeat (5) step();
    check("hold_no_busy", 64'(busy_cyc), 64'(0));
    check("hold_no_done", 64'(done_cnt), 64'(0));
    check("hold_snap_count", 64'(bus.snap_count), 64'(exp_snaps));
    check_disp("hold_disp5", disp_tbl[1].addr, disp_tbl[1].exp);

    // Two frame pulses during a scan merge into one extra snapshot
    base     = 32'hC000_0000;
    done_cnt = 0;
    busy_cyc = 0;
    pulse_frame();
    wait_busy("dbl_scan_start");
    repeat (3) step();
    pulse_frame();
    step();
    pulse_frame();
    wait_done(2, 150);
    repeat (40) step();
    exp_snaps += 2;
    check("dbl_done_cnt", 64'(done_cnt), 64'(2));
    check("dbl_busy_cycles", 64'(busy_cyc), 64'(64));
    check("dbl_snap_count", 64'(bus.snap_count), 64'(exp_snaps));
    check_disp("dbl_disp9", 5'd9, 32'hC000_0009);

    // Reset asserted mid-scan at idx 10
    pulse_frame();
    wait_busy("rst_scan_start");
    repeat (10) step();
    check("rst_scan_idx", 64'(bus.rf_addr), 64'(10));
    resetn = 1'b0;
    #1;
    check_all_zero("rst_mid");
    for (int i = 0; i < NR; i++) check_disp("rst_mid_disp", 5'(i), 32'h0);
    step();
    resetn = 1'b1;
    repeat (3) step();
    check("rst_after_idle", 64'(bus.snap_busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
